core_sequencer: RTL and testbench
=================================

# core_sequencer

Multicycle instruction sequencer for the core, parametrised in data width, register count and read-port count. Owns the PC, the GPR and FPR register files and the per-instruction FSM. Handshakes with the external fetcher, executor and a new load/store memory unit. Adds two things a fixed-width sequencer lacks: illegal-instruction traps and a debug halt/single-step mode.

## Interface
Parameters:
- XLEN, 32, data/PC width
- REG_ADDR_W, 5, register index width; each file holds 2**REG_ADDR_W entries
- NUM_READ, 3, operand read ports per file
- RESET_PC, 0, PC after reset
- TRAP_PC, 'h100, PC loaded on illegal instruction

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- fetch_req  out  1  high for the whole FETCH state
- fetch_done  in  1  fetcher completion; ignored outside FETCH
- pc  out  XLEN  current instruction address
- instruction  in  32  fetched word; valid with fetch_done
- inst  out  32  instruction latched on fetch_done, drives the external decoder
- dec_src  in  NUM_READ*REG_ADDR_W  operand indices
- dec_dst  in  REG_ADDR_W  destination index
- dec_wr_gpr, dec_wr_fpr, dec_mem, dec_illegal  in  1 each  decoder flags
- exec_req  out  1  high for the whole EXEC state
- exec_done  in  1  executor completion; ignored outside EXEC
- exec_result  in  XLEN  ALU result, or the effective address when dec_mem is set
- exec_next_pc  in  XLEN  next PC
- gpr_rd, fpr_rd  out  NUM_READ*XLEN  combinational reads at dec_src
- mem_req  out  1  high for the whole MEM state
- mem_done  in  1  memory completion; ignored outside MEM
- mem_rdata  in  XLEN  load data
- halt_req  in  1  debug halt request (level)
- step  in  1  single-step pulse, honoured only in HALT
- halted  out  1  high in HALT
- trap  out  1  one-cycle pulse on illegal instruction
- epc  out  XLEN  PC of the last trapping instruction
- retired  out  32  retired-instruction counter

## Operation
- States: INIT, FETCH, DECODE, EXEC, MEM, HALT.
- INIT always goes to the dispatch decision.
- Dispatch decision (taken at INIT exit and at every retire or trap): go to HALT if halt_req is high, or if the instruction just finished was started by a step; otherwise go to FETCH.
- FETCH: on fetch_done, latch inst and go to DECODE.
- DECODE:
  - dec_illegal=1: pulse trap, epc<=pc, pc<=TRAP_PC, no writeback, retired unchanged, then dispatch.
  - otherwise go to EXEC.
- EXEC: on exec_done, latch exec_result (address) and exec_next_pc.
  - dec_mem=1: go to MEM.
  - dec_mem=0: retire with writeback data exec_result.
- MEM: on mem_done, retire with writeback data mem_rdata.
- Retire, all in one cycle:
  - pc <= {next_pc[XLEN-1:2],2'b00}
  - retired <= retired+1, wrapping at 2^32
  - write GPR[dec_dst] if dec_wr_gpr and dec_dst!=0
  - write FPR[dec_dst] if dec_wr_fpr; FPR 0 is writable
  - if both flags are set, write both files
- HALT: halted=1.
  - step=1: go to FETCH and run exactly one instruction (or trap), then dispatch again.
  - halt_req=0: go to FETCH.
  - step and halt_req low in the same cycle: step wins.
- GPR 0 always reads 0.
- Decoder inputs must stay stable from DECODE through retire; inst only changes on fetch_done.
- Reset values: state INIT; pc RESET_PC; all registers, inst, epc and retired 0; all req outputs, trap and halted 0.
- Reset mid-instruction aborts it: no writeback, no count, all req outputs drop the following cycle.

## Timing
- With zero-wait units each instruction takes 3 cycles (FETCH, DECODE, EXEC), or 4 with MEM.
- A done input may arrive in the first cycle its req is high.
- A trapping instruction takes 2 cycles (FETCH, DECODE); trap is high in the DECODE cycle.
- Register writes are visible on gpr_rd/fpr_rd from the cycle after retire; no bypassing.
- halt_req asserted mid-instruction takes effect at the next dispatch; the current instruction completes.

## Structure
- Package core_pkg holds:
  - state enum core_state_e
  - default XLEN, TRAP_PC and RESET_PC constants
- Sub-module reg_file, parametrised by XLEN, REG_ADDR_W, NUM_READ and ZERO_R0.
  - One instance with ZERO_R0=1 for the GPRs, one with ZERO_R0=0 for the FPRs.
  - Synchronous write, combinational reads.

## Test plan
- ALU op with dec_dst=3, dec_wr_gpr=1, exec_result=0xDEADBEEF, exec_next_pc=0x7 -> GPR3=0xDEADBEEF, pc=0x4, retired=1, 3 cycles from FETCH entry.
- Load with dec_mem=1, dec_wr_fpr=1, dec_dst=0, mem_rdata=0x12345678 -> FPR0=0x12345678, MEM state entered, GPR0 still reads 0.
- Write to GPR0 with exec_result=0xFFFFFFFF -> gpr_rd for index 0 reads 0.
- dec_illegal at pc=0x40 -> one-cycle trap, epc=0x40, pc=0x100, retired unchanged, no register write.
- halt_req held high -> halted after the current retire; each step pulse gives exactly one FETCH..retire then HALT; dropping halt_req resumes free-running.
- reset asserted in the exec_done cycle -> no writeback, pc=RESET_PC, retired=0, exec_req low the next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared state encoding and default constants for the core sequencer.
package core_pkg;

   typedef enum logic [2:0] {
      S_INIT,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_HALT
   } core_state_e;

   localparam int          DEF_XLEN     = 32;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_PC  = 32'h0000_0100;

endpackage

// File: rtl/reg_file.sv
// Register file: synchronous single write port, NUM_READ combinational read ports.
// With ZERO_R0 set, entry 0 reads as zero and ignores writes.
module reg_file #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int NUM_READ   = 3,
   parameter bit ZERO_R0    = 1'b0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           we,
   input  logic [REG_ADDR_W-1:0]          waddr,
   input  logic [XLEN-1:0]                wdata,
   input  logic [NUM_READ*REG_ADDR_W-1:0] raddr,
   output logic [NUM_READ*XLEN-1:0]       rdata
);

   localparam int DEPTH = 2**REG_ADDR_W;

   logic [XLEN-1:0] regs [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (we && !(ZERO_R0 && waddr == '0)) begin
         regs[waddr] <= wdata;
      end
   end

   for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
      logic [REG_ADDR_W-1:0] a;
      assign a = raddr[r*REG_ADDR_W +: REG_ADDR_W];
      assign rdata[r*XLEN +: XLEN] = (ZERO_R0 && a == '0) ? '0 : regs[a];
   end

endmodule

// File: rtl/core_sequencer.sv
// Multicycle instruction sequencer: PC, GPR/FPR files, fetch/exec/mem handshakes,
// illegal-instruction trap and debug halt/single-step.
module core_sequencer
   import core_pkg::*;
#(
   parameter int              XLEN       = DEF_XLEN,
   parameter int              REG_ADDR_W = 5,
   parameter int              NUM_READ   = 3,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
   parameter logic [XLEN-1:0] TRAP_PC    = XLEN'(DEF_TRAP_PC)
) (
   input  logic                           clk,
   input  logic                           reset,
   output logic                           fetch_req,
   input  logic                           fetch_done,
   output logic [XLEN-1:0]                pc,
   input  logic [31:0]                    instruction,
   output logic [31:0]                    inst,
   input  logic [NUM_READ*REG_ADDR_W-1:0] dec_src,
   input  logic [REG_ADDR_W-1:0]          dec_dst,
   input  logic                           dec_wr_gpr,
   input  logic                           dec_wr_fpr,
   input  logic                           dec_mem,
   input  logic                           dec_illegal,
   output logic                           exec_req,
   input  logic                           exec_done,
   input  logic [XLEN-1:0]                exec_result,
   input  logic [XLEN-1:0]                exec_next_pc,
   output logic [NUM_READ*XLEN-1:0]       gpr_rd,
   output logic [NUM_READ*XLEN-1:0]       fpr_rd,
   output logic                           mem_req,
   input  logic                           mem_done,
   input  logic [XLEN-1:0]                mem_rdata,
   input  logic                           halt_req,
   input  logic                           step,
   output logic                           halted,
   output logic                           trap,
   output logic [XLEN-1:0]                epc,
   output logic [31:0]                    retired
);

   core_state_e     state, state_n;
   logic            step_mode;
   logic [XLEN-1:0] npc_q;
   logic            retire, dispatch;
   logic [XLEN-1:0] wb_data, retire_pc;
   logic            gpr_we, fpr_we;

   always_ff @(posedge clk) begin
      if (reset) state <= S_INIT;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      fetch_req = 1'b0;
      exec_req  = 1'b0;
      mem_req   = 1'b0;
      halted    = 1'b0;
      trap      = 1'b0;
      retire    = 1'b0;
      dispatch  = 1'b0;
      wb_data   = exec_result;
      retire_pc = exec_next_pc;
      case (state)
         S_INIT:   dispatch = 1'b1;
         S_FETCH: begin
            fetch_req = 1'b1;
            if (fetch_done) state_n = S_DECODE;
         end
         S_DECODE: begin
            if (dec_illegal) begin
               trap     = 1'b1;
               dispatch = 1'b1;
            end else begin
               state_n = S_EXEC;
            end
         end
         S_EXEC: begin
            exec_req = 1'b1;
            if (exec_done) begin
               if (dec_mem) begin
                  state_n = S_MEM;
               end else begin
                  retire   = 1'b1;
                  dispatch = 1'b1;
               end
            end
         end
         S_MEM: begin
            mem_req   = 1'b1;
            wb_data   = mem_rdata;
            retire_pc = npc_q;
            if (mem_done) begin
               retire   = 1'b1;
               dispatch = 1'b1;
            end
         end
         S_HALT: begin
            halted = 1'b1;
            if (step || !halt_req) state_n = S_FETCH;
         end
         default: state_n = S_INIT;
      endcase
      // An instruction launched by a step always returns to HALT.
      if (dispatch) state_n = (halt_req || step_mode) ? S_HALT : S_FETCH;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc        <= RESET_PC;
         inst      <= '0;
         epc       <= '0;
         retired   <= '0;
         npc_q     <= '0;
         step_mode <= 1'b0;
      end else begin
         if (state == S_FETCH && fetch_done) inst <= instruction;
         if (state == S_EXEC && exec_done) npc_q <= exec_next_pc;
         if (trap) begin
            epc <= pc;
            pc  <= TRAP_PC;
         end
         if (retire) begin
            pc      <= {retire_pc[XLEN-1:2], 2'b00};
            retired <= retired + 32'd1;
         end
         if (dispatch) step_mode <= 1'b0;
         if (state == S_HALT && step) step_mode <= 1'b1;
      end
   end

   assign gpr_we = retire && dec_wr_gpr && (dec_dst != '0);
   assign fpr_we = retire && dec_wr_fpr;

   reg_file #(
      .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .NUM_READ(NUM_READ), .ZERO_R0(1'b1)
   ) u_gpr (
      .clk(clk), .reset(reset), .we(gpr_we), .waddr(dec_dst), .wdata(wb_data),
      .raddr(dec_src), .rdata(gpr_rd)
   );

   reg_file #(
      .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .NUM_READ(NUM_READ), .ZERO_R0(1'b0)
   ) u_fpr (
      .clk(clk), .reset(reset), .we(fpr_we), .waddr(dec_dst), .wdata(wb_data),
      .raddr(dec_src), .rdata(fpr_rd)
   );

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: acts as fetcher/executor/memory unit with random waits,
// checking PC, counters and register contents against an architectural model.
module tb_core_sequencer;

   localparam logic [31:0] TRAP_PC = 32'h100;

   logic        clk, reset;
   logic        fetch_req, fetch_done;
   logic [31:0] pc, instruction, inst;
   logic [14:0] dec_src;
   logic [4:0]  dec_dst;
   logic        dec_wr_gpr, dec_wr_fpr, dec_mem, dec_illegal;
   logic        exec_req, exec_done;
   logic [31:0] exec_result, exec_next_pc;
   logic [95:0] gpr_rd, fpr_rd;
   logic        mem_req, mem_done;
   logic [31:0] mem_rdata;
   logic        halt_req, step, halted, trap;
   logic [31:0] epc, retired;

   core_sequencer dut (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_done(fetch_done),
      .pc(pc), .instruction(instruction), .inst(inst), .dec_src(dec_src),
      .dec_dst(dec_dst), .dec_wr_gpr(dec_wr_gpr), .dec_wr_fpr(dec_wr_fpr),
      .dec_mem(dec_mem), .dec_illegal(dec_illegal), .exec_req(exec_req),
      .exec_done(exec_done), .exec_result(exec_result), .exec_next_pc(exec_next_pc),
      .gpr_rd(gpr_rd), .fpr_rd(fpr_rd), .mem_req(mem_req), .mem_done(mem_done),
      .mem_rdata(mem_rdata), .halt_req(halt_req), .step(step), .halted(halted),
      .trap(trap), .epc(epc), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Architectural model
   logic [31:0] m_gpr [32];
   logic [31:0] m_fpr [32];
   logic [31:0] m_pc, m_epc, m_retired;

   // Random instruction fields
   logic        r_ill, r_mem, r_wg, r_wf;
   logic [4:0]  r_dst;
   logic [31:0] r_res, r_npc, r_rd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_gpr[i] = '0;
         m_fpr[i] = '0;
      end
      m_pc      = 32'h0;
      m_epc     = 32'h0;
      m_retired = 32'h0;
   endtask

   task automatic check_regs(input logic [4:0] idx);
      logic [4:0] r1;
      r1 = 5'($urandom);
      dec_src = {5'd0, r1, idx};
      #1;
      chk("gpr_p0", gpr_rd[31:0], m_gpr[idx]);
      chk("gpr_p1", gpr_rd[63:32], m_gpr[r1]);
      chk("gpr_zero", gpr_rd[95:64], 32'h0);
      chk("fpr_p0", fpr_rd[31:0], m_fpr[idx]);
      chk("fpr_p1", fpr_rd[63:32], m_fpr[r1]);
   endtask

   task automatic run_instr(input logic ill, input logic mm, input logic wg, input logic wf,
                            input logic [4:0] dst, input logic [31:0] res,
                            input logic [31:0] npc, input logic [31:0] rd,
                            input int maxw, input logic exp_halt);
      int          n;
      logic [31:0] w, wdat;
      n = 0;
      while (!fetch_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("fetch_req", 32'(fetch_req), 32'd1);
      chk("pc_at_fetch", pc, m_pc);
      repeat ($urandom_range(maxw, 0)) @(negedge clk);
      w           = $urandom;
      instruction = w;
      fetch_done  = 1'b1;
      dec_dst     = dst;
      dec_illegal = ill;
      dec_mem     = mm;
      dec_wr_gpr  = wg;
      dec_wr_fpr  = wf;
      dec_src     = 15'($urandom);
      @(negedge clk);
      fetch_done = 1'b0;
      chk("inst", inst, w);
      chk("trap", 32'(trap), 32'(ill));
      if (ill) begin
         m_epc = m_pc;
         m_pc  = TRAP_PC;
      end else begin
         @(negedge clk);
         chk("exec_req", 32'(exec_req), 32'd1);
         repeat ($urandom_range(maxw, 0)) @(negedge clk);
         exec_result  = res;
         exec_next_pc = npc;
         exec_done    = 1'b1;
         if (mm) begin
            @(negedge clk);
            exec_done = 1'b0;
            chk("mem_req", 32'(mem_req), 32'd1);
            repeat ($urandom_range(maxw, 0)) @(negedge clk);
            mem_rdata = rd;
            mem_done  = 1'b1;
         end
         wdat      = mm ? rd : res;
         m_pc      = npc & ~32'h3;
         m_retired = m_retired + 32'd1;
         if (wg && dst != 5'd0) m_gpr[dst] = wdat;
         if (wf) m_fpr[dst] = wdat;
      end
      @(negedge clk);
      exec_done = 1'b0;
      mem_done  = 1'b0;
      chk("pc", pc, m_pc);
      chk("retired", retired, m_retired);
      chk("epc", epc, m_epc);
      chk("trap_clear", 32'(trap), 32'd0);
      chk("halted", 32'(halted), 32'(exp_halt));
      chk("fetch_req_next", 32'(fetch_req), 32'(!exp_halt));
      check_regs(dst);
   endtask

   task automatic rand_fields();
      r_ill = ($urandom_range(7, 0) == 0);
      r_mem = ($urandom_range(2, 0) == 0);
      r_wg  = 1'($urandom);
      r_wf  = 1'($urandom);
      r_dst = 5'($urandom);
      r_res = $urandom;
      r_npc = $urandom;
      r_rd  = $urandom;
   endtask

   initial begin
      int n;
      reset = 1'b1; fetch_done = 1'b0; instruction = '0; dec_src = '0; dec_dst = '0;
      dec_wr_gpr = 1'b0; dec_wr_fpr = 1'b0; dec_mem = 1'b0; dec_illegal = 1'b0;
      exec_done = 1'b0; exec_result = '0; exec_next_pc = '0; mem_done = 1'b0;
      mem_rdata = '0; halt_req = 1'b0; step = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_fetch_req", 32'(fetch_req), 32'd0);
      chk("rst_exec_req", 32'(exec_req), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_trap", 32'(trap), 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_epc", epc, 32'h0);
      chk("rst_retired", retired, 32'h0);
      reset = 1'b0;

      // Directed cases
      run_instr(0, 0, 1, 0, 5'd3, 32'hDEADBEEF, 32'h7, 32'h0, 0, 0);
      run_instr(0, 1, 0, 1, 5'd0, 32'h0000_0200, 32'h8, 32'h12345678, 0, 0);
      run_instr(0, 0, 1, 0, 5'd0, 32'hFFFFFFFF, 32'h40, 32'h0, 1, 0);
      run_instr(1, 0, 1, 1, 5'd7, 32'h0000_AAAA, 32'h0, 32'h0, 1, 0);

      for (int k = 0; k < 40; k++) begin
         rand_fields();
         run_instr(r_ill, r_mem, r_wg, r_wf, r_dst, r_res, r_npc, r_rd, 2, 0);
      end

      // Halt, then single-step with halt held, with a trap, and with halt released
      halt_req = 1'b1;
      rand_fields();
      run_instr(0, r_mem, r_wg, r_wf, r_dst, r_res, r_npc, r_rd, 2, 1);
      repeat (3) @(negedge clk);
      chk("halt_hold", 32'(halted), 32'd1);
      chk("halt_no_fetch", 32'(fetch_req), 32'd0);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      rand_fields();
      run_instr(0, r_mem, r_wg, r_wf, r_dst, r_res, r_npc, r_rd, 1, 1);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      run_instr(1, 0, 1, 1, 5'd9, 32'h1, 32'h4, 32'h0, 1, 1);
      step = 1'b1;
      halt_req = 1'b0;
      @(negedge clk);
      step = 1'b0;
      rand_fields();
      run_instr(0, r_mem, r_wg, r_wf, r_dst, r_res, r_npc, r_rd, 1, 1);
      rand_fields();
      run_instr(0, r_mem, r_wg, r_wf, r_dst, r_res, r_npc, r_rd, 1, 0);

      // Reset landing in the exec_done cycle
      n = 0;
      while (!fetch_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rst_test_fetch", 32'(fetch_req), 32'd1);
      instruction = 32'h1234; fetch_done = 1'b1; dec_illegal = 1'b0; dec_mem = 1'b0;
      dec_wr_gpr = 1'b1; dec_wr_fpr = 1'b0; dec_dst = 5'd5;
      @(negedge clk);
      fetch_done = 1'b0;
      @(negedge clk);
      chk("rst_test_exec", 32'(exec_req), 32'd1);
      exec_result = 32'h5555_5555; exec_next_pc = 32'h80; exec_done = 1'b1; reset = 1'b1;
      @(negedge clk);
      exec_done = 1'b0;
      chk("abort_exec_req", 32'(exec_req), 32'd0);
      chk("abort_pc", pc, 32'h0);
      chk("abort_retired", retired, 32'h0);
      reset = 1'b0;
      model_reset();
      check_regs(5'd5);

      for (int k = 0; k < 6; k++) begin
         rand_fields();
         run_instr(r_ill, r_mem, r_wg, r_wf, r_dst, r_res, r_npc, r_rd, 2, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
